des_key_sched_ctrl: RTL and testbench

- Iterative DES key-schedule sequencer; replaces the fully unrolled 16-subkey generator where area matters.
- Latches a 64-bit key, applies PC-1, then emits one 48-bit subkey per round over a valid/ready handshake to the round datapath.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1); signals completion and accepts an abort.

---
 rtl/des_pkg.sv | 61 ++++++
 rtl/des_pc2.sv | 16 +
 rtl/des_key_sched_ctrl.sv | 110 +++++++++++
 tb/tb_des_key_sched_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule constants: PC-1/PC-2 tables, per-round shift schedule,
// sequencer state encoding and the PC-1 / 28-bit rotate helpers.
package des_pkg;

  localparam int unsigned DES_ROUNDS = 16;
  localparam int unsigned KEY_W      = 64;
  localparam int unsigned CD_W       = 28;
  localparam int unsigned SUBKEY_W   = 48;

  // Table entries use DES numbering: bit 1 is the MSB of the vector.
  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // SHIFT_TBL[i] holds s[i+1]
  localparam int unsigned SHIFT_TBL [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left,
                                        input logic two);
    logic [27:0] r;
    if (left) r = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    else      r = two ? {x[1:0], x[27:2]}   : {x[0], x[27:1]};
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the 56-bit {C,D} pair to a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0]   cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  always_comb begin
    subkey_o = '0;
    for (int unsigned i = 0; i < SUBKEY_W; i++) begin
      subkey_o[6'(47 - i)] = cd_i[6'(56 - PC2_TBL[i])];
    end
  end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// Iterative DES key-schedule sequencer: one PC-2 subkey per accepted
// handshake, K1..K16 for encrypt or K16..K1 for decrypt.
module des_key_sched_ctrl
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                decrypt_i,
  input  logic [KEY_W-1:0]    key_i,
  input  logic                abort_i,
  output logic                ready_o,
  output logic [SUBKEY_W-1:0] subkey_o,
  output logic [3:0]          round_o,
  output logic                subkey_valid_o,
  input  logic                subkey_ready_i,
  output logic                done_o
);

  state_t         state_q, state_d;
  logic [CD_W-1:0] c_q, c_d, d_q, d_d;
  logic           dir_q, dir_d;
  logic [3:0]     cnt_q, cnt_d;

  logic [2*CD_W-1:0] key_pc1;
  logic [3:0]        shift_idx;
  logic              shift_two;

  assign key_pc1 = pc1(key_i);

  // Encrypt walks s[cnt+2] forward; decrypt walks s[16-cnt] backward.
  always_comb begin
    shift_idx = dir_q ? (4'd15 - cnt_q) : (cnt_q + 4'd1);
    shift_two = (SHIFT_TBL[shift_idx] == 2);
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          dir_d   = decrypt_i;
          cnt_d   = '0;
          state_d = ROUND;
          if (decrypt_i) begin
            c_d = key_pc1[55:28];
            d_d = key_pc1[27:0];
          end else begin
            c_d = rot28(key_pc1[55:28], 1'b1, 1'b0);
            d_d = rot28(key_pc1[27:0], 1'b1, 1'b0);
          end
        end
      end
      ROUND: begin
        if (subkey_ready_i) begin
          if (cnt_q == 4'd15) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
            c_d   = rot28(c_q, !dir_q, shift_two);
            d_d   = rot28(d_q, !dir_q, shift_two);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      c_d     = c_q;
      d_d     = d_q;
      dir_d   = dir_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (subkey_o)
  );

  assign ready_o        = (state_q == IDLE);
  assign subkey_valid_o = (state_q == ROUND);
  assign done_o         = (state_q == DONE) && !abort_i;
  assign round_o        = cnt_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl against hand-derived DES subkeys.
module tb_des_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        decrypt_i;
  logic [63:0] key_i;
  logic        abort_i;
  logic        ready_o;
  logic [47:0] subkey_o;
  logic [3:0]  round_o;
  logic        subkey_valid_o;
  logic        subkey_ready_i;
  logic        done_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P  = 64'h133457799BBCDFF0;
  localparam logic [63:0] KEY_0C = 64'h0C0C0C0C0C0C0C0C;

  localparam logic [47:0] K_ENC [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  localparam logic [47:0] K_0C [16] = '{
    48'h00000099DE3C, 48'h000000995E3C, 48'h000000997AB4, 48'h000000B16AB5,
    48'h000000B32A97, 48'h000000B72397, 48'h0000003723C7, 48'h00000076A1C7,
    48'h00000076A1CF, 48'h00000066B5CB, 48'h0000006EB56B, 48'h0000006EDD6A,
    48'h0000004CDD7A, 48'h000000CDDC78, 48'h000000C9DE78, 48'h000000D9DE38
  };

  always #5 clk = ~clk;

  des_key_sched_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .decrypt_i      (decrypt_i),
    .key_i          (key_i),
    .abort_i        (abort_i),
    .ready_o        (ready_o),
    .subkey_o       (subkey_o),
    .round_o        (round_o),
    .subkey_valid_o (subkey_valid_o),
    .subkey_ready_i (subkey_ready_i),
    .done_o         (done_o)
  );

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; decrypt_i = 1'b0; key_i = '0;
    abort_i = 1'b0; subkey_ready_i = 1'b0;
    #3;
    n_cmp++;
    if (ready_o !== 1'b1 || subkey_valid_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: ready=%b valid=%b done=%b, want 1 0 0",
               ready_o, subkey_valid_o, done_o);
    end
    n_cmp++;
    if (round_o !== 4'd0 || subkey_o !== 48'h0) begin
      n_err++;
      $display("FAIL reset_data: round=%0d subkey=%h, want 0 0", round_o, subkey_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1 || subkey_valid_o !== 1'b0 || subkey_o !== 48'h0) begin
      n_err++;
      $display("FAIL post_reset_idle: ready=%b valid=%b subkey=%h, want 1 0 0",
               ready_o, subkey_valid_o, subkey_o);
    end
  endtask

  task automatic test_encrypt();
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_err++; $display("FAIL enc_ready_before: got %b want 1", ready_o);
    end
    key_i = KEY_A; decrypt_i = 1'b0; subkey_ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (subkey_valid_o !== 1'b1 || round_o !== 4'(i) || subkey_o !== K_ENC[i]) begin
        n_err++;
        $display("FAIL enc_round%0d: valid=%b round=%0d subkey=%h, want 1 %0d %h",
                 i, subkey_valid_o, round_o, subkey_o, i, K_ENC[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b1 || subkey_valid_o !== 1'b0 || ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL enc_done_cycle17: done=%b valid=%b ready=%b, want 1 0 0",
               done_o, subkey_valid_o, ready_o);
    end
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL enc_after_done: done=%b ready=%b, want 0 1", done_o, ready_o);
    end
  endtask

  task automatic test_decrypt();
    @(negedge clk);
    key_i = KEY_A; decrypt_i = 1'b1; subkey_ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0; decrypt_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (subkey_valid_o !== 1'b1 || round_o !== 4'(i) || subkey_o !== K_ENC[15-i]) begin
        n_err++;
        $display("FAIL dec_round%0d: valid=%b round=%0d subkey=%h, want 1 %0d %h",
                 i, subkey_valid_o, round_o, subkey_o, i, K_ENC[15-i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b1 || subkey_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL dec_done: done=%b valid=%b, want 1 0", done_o, subkey_valid_o);
    end
    @(negedge clk);
  endtask

  task automatic test_random_stall();
    int   exp_i;
    int   cyc;
    int   done_cnt;
    logic rdy;
    @(negedge clk);
    key_i = KEY_0C; decrypt_i = 1'b0; subkey_ready_i = 1'b0; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    exp_i = 0; cyc = 0; done_cnt = 0;
    while (exp_i < 16 && cyc < 200) begin
      n_cmp++;
      if (subkey_valid_o !== 1'b1 || round_o !== 4'(exp_i) || subkey_o !== K_0C[exp_i]) begin
        n_err++;
        $display("FAIL stall_round%0d: valid=%b round=%0d subkey=%h, want 1 %0d %h",
                 exp_i, subkey_valid_o, round_o, subkey_o, exp_i, K_0C[exp_i]);
      end
      rdy = 1'($urandom_range(0, 1));
      subkey_ready_i = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) exp_i++;
    end
    n_cmp++;
    if (exp_i != 16) begin
      n_err++; $display("FAIL stall_timeout: accepted %0d subkeys, want 16", exp_i);
    end
    subkey_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done_o === 1'b1) done_cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++; $display("FAIL stall_done_count: got %0d pulses want 1", done_cnt);
    end
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_err++; $display("FAIL stall_ready_end: got %b want 1", ready_o);
    end
  endtask

  task automatic test_abort();
    int done_cnt;
    @(negedge clk);
    key_i = KEY_A; decrypt_i = 1'b0; subkey_ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    n_cmp++;
    if (round_o !== 4'd7 || subkey_o !== K_ENC[7]) begin
      n_err++;
      $display("FAIL abort_at7: round=%0d subkey=%h, want 7 %h", round_o, subkey_o, K_ENC[7]);
    end
    abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    n_cmp++;
    if (subkey_valid_o !== 1'b0 || ready_o !== 1'b1 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: valid=%b ready=%b done=%b, want 0 1 0",
               subkey_valid_o, ready_o, done_o);
    end
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_o === 1'b1) done_cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (done_cnt != 0) begin
      n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt);
    end
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk); start_i = 1'b0; abort_i = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b1 || subkey_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort_beats_start: ready=%b valid=%b, want 1 0", ready_o, subkey_valid_o);
    end
    decrypt_i = 1'b1; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n_cmp++;
    if (subkey_valid_o !== 1'b1 || round_o !== 4'd0 || subkey_o !== K_ENC[15]) begin
      n_err++;
      $display("FAIL abort_restart_k16: valid=%b round=%0d subkey=%h, want 1 0 %h",
               subkey_valid_o, round_o, subkey_o, K_ENC[15]);
    end
    @(negedge clk);
    n_cmp++;
    if (round_o !== 4'd1 || subkey_o !== K_ENC[14]) begin
      n_err++;
      $display("FAIL abort_restart_k15: round=%0d subkey=%h, want 1 %h",
               round_o, subkey_o, K_ENC[14]);
    end
    abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0; decrypt_i = 1'b0;
  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    key_i = KEY_A; decrypt_i = 1'b0; subkey_ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (subkey_valid_o !== 1'b1 || round_o !== 4'(i) || subkey_o !== K_ENC[i]) begin
        n_err++;
        $display("FAIL midrun_round%0d: valid=%b round=%0d subkey=%h, want 1 %0d %h",
                 i, subkey_valid_o, round_o, subkey_o, i, K_ENC[i]);
      end
      key_i     = ~key_i;
      decrypt_i = ~decrypt_i;
      start_i   = (i == 2);
    end
    start_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ready_o !== 1'b1 || subkey_valid_o !== 1'b0 || done_o !== 1'b0 ||
        round_o !== 4'd0 || subkey_o !== 48'h0) begin
      n_err++;
      $display("FAIL midrun_async_reset: ready=%b valid=%b done=%b round=%0d subkey=%h, want 1 0 0 0 0",
               ready_o, subkey_valid_o, done_o, round_o, subkey_o);
    end
    @(negedge clk); rst_n = 1'b1; key_i = KEY_A; decrypt_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1 || done_o !== 1'b0 || subkey_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_after_reset: ready=%b done=%b valid=%b, want 1 0 0",
               ready_o, done_o, subkey_valid_o);
    end
  endtask

  task automatic test_parity();
    @(negedge clk);
    key_i = KEY_P; decrypt_i = 1'b0; subkey_ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (subkey_o !== K_ENC[i] || round_o !== 4'(i)) begin
        n_err++;
        $display("FAIL parity_round%0d: round=%0d subkey=%h, want %0d %h",
                 i, round_o, subkey_o, i, K_ENC[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_err++; $display("FAIL parity_done: got %b want 1", done_o);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_random_stall();
    test_abort();
    test_midrun_reset();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
